// File: rtl/conv_mem_host.sv
// Memory host for a convolution engine: loads a 64x64 image, serves engine
// reads/writes to two layer buffers, then optionally streams both layers out.
module conv_mem_host #(
  parameter bit DUMP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [12:0] ld_data,
  output logic        ld_ready,
  output logic        ready,
  input  logic        busy,
  input  logic [11:0] iaddr,
  output logic [12:0] idata,
  input  logic        cwr,
  input  logic [11:0] caddr_wr,
  input  logic [12:0] cdata_wr,
  input  logic        crd,
  input  logic [11:0] caddr_rd,
  output logic [12:0] cdata_rd,
  input  logic        csel,
  output logic        dp_valid,
  input  logic        dp_ready,
  output logic        dp_sel,
  output logic [11:0] dp_addr,
  output logic [12:0] dp_data,
  output logic        dp_last,
  output logic        err,
  output logic        done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t      state;
  logic [11:0] ld_cnt;

  logic [12:0] img [0:4095];
  logic [12:0] l0  [0:4095];
  logic [12:0] l1  [0:1023];

  logic layer_wr;
  logic l0_we;
  logic l1_we;
  logic l1_oob;

  assign layer_wr = !reset && (state == S_RUN) && cwr;
  assign l0_we    = layer_wr && !csel;
  assign l1_oob   = layer_wr && csel && (caddr_wr[11:10] != 2'b00);
  assign l1_we    = layer_wr && csel && (caddr_wr[11:10] == 2'b00);

  // Asynchronous read ports; a same-cycle write only lands at the next edge,
  // so a colliding read naturally returns the old word.
  assign idata    = img[iaddr];
  assign cdata_rd = !crd ? 13'd0 : (csel ? l1[caddr_rd[9:0]] : l0[caddr_rd]);
  assign dp_data  = !dp_valid ? 13'd0 : (dp_sel ? l1[dp_addr[9:0]] : l0[dp_addr]);

  // NOTE: the arrays have no reset branch -- contents must survive reset, and
  // a reset on a large array would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (!reset && (state == S_LOAD) && ld_valid) img[ld_cnt] <= ld_data;
    if (l0_we) l0[caddr_wr] <= cdata_wr;
    if (l1_we) l1[caddr_wr[9:0]] <= cdata_wr;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOAD;
      ld_cnt   <= '0;
      ld_ready <= 1'b1;
      ready    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      dp_valid <= 1'b0;
      dp_last  <= 1'b0;
      dp_sel   <= 1'b0;
      dp_addr  <= '0;
    end else begin
      if (l1_oob) err <= 1'b1;
      case (state)
        S_LOAD: begin
          if (ld_valid) begin
            ld_cnt <= ld_cnt + 12'd1;
            if (ld_cnt == 12'hfff) begin
              state    <= S_ARM;
              ld_ready <= 1'b0;
              ready    <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (busy) begin
            state <= S_RUN;
            ready <= 1'b0;
          end
        end
        S_RUN: begin
          // busy was high on entry, so a low sample here is the falling edge
          if (!busy) begin
            if (DUMP_EN) begin
              state    <= S_DUMP;
              dp_valid <= 1'b1;
              dp_sel   <= 1'b0;
              dp_addr  <= '0;
              dp_last  <= 1'b0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (dp_ready) begin
            if (dp_last) begin
              state    <= S_DONE;
              done     <= 1'b1;
              dp_valid <= 1'b0;
              dp_last  <= 1'b0;
            end else begin
              dp_addr <= dp_addr + 12'd1;
              if (!dp_sel && (dp_addr == 12'hfff)) dp_sel <= 1'b1;
              dp_last <= dp_sel && (dp_addr == 12'd1022);
            end
          end
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host: image load, engine handshake, layer
// access rules, dump ordering with a scoreboard, and reset mid-dump.
module tb_conv_mem_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic [12:0] ld_data = '0;
  logic        ld_ready;
  logic        ready;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [12:0] idata;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [12:0] cdata_wr = '0;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic [12:0] cdata_rd;
  logic        csel = 1'b0;
  logic        dp_valid;
  logic        dp_ready = 1'b0;
  logic        dp_sel;
  logic [11:0] dp_addr;
  logic [12:0] dp_data;
  logic        dp_last;
  logic        err;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        sel;
    logic [11:0] addr;
    logic [12:0] data;
    logic        last;
  } dump_t;

  dump_t       exp_q [$];
  logic [12:0] img_m [4096];
  logic [12:0] l0_m  [4096];
  logic [12:0] l1_m  [1024];

  always #5 clk = ~clk;

  conv_mem_host #(.DUMP_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_sel(dp_sel),
    .dp_addr(dp_addr), .dp_data(dp_data), .dp_last(dp_last),
    .err(err), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ld_ready, ready, done, dp_valid, dp_last, dp_sel, err} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_flags: got ld_ready/ready/done/dp_valid/dp_last/dp_sel/err=%b want 1000000",
               {ld_ready, ready, done, dp_valid, dp_last, dp_sel, err});
    end
    vectors++;
    if ({dp_addr, dp_data} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_dp: got addr=%h data=%h want 0/0", dp_addr, dp_data);
    end
    tick();
  endtask

  // Streams 4096 words (addr ^ pat) with random gaps and a busy pulse in LOAD.
  task automatic load_image(input logic [12:0] pat);
    int acc = 0;
    int cyc = 0;
    while (acc < 4096 && cyc < 20000) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = 13'(acc) ^ pat;
      busy     = (acc >= 100 && acc < 103);
      @(negedge clk);
      if (ld_valid && acc == 4095) begin
        vectors++;
        if (ready !== 1'b0 || ld_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL load_last_accept: got ready=%b ld_ready=%b want 0/1", ready, ld_ready);
        end
      end
      if (ld_valid && ld_ready) begin
        img_m[acc] = ld_data;
        acc++;
      end
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    busy     = 1'b0;
    if (acc < 4096) begin
      miscompares++;
      $display("FAIL load_timeout: accepted %0d want 4096", acc);
    end
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_ready: got ready=%b ld_ready=%b want 1/0", ready, ld_ready);
    end
    iaddr = 12'h041;
    #1;
    vectors++;
    if (idata !== img_m[12'h041]) begin
      miscompares++;
      $display("FAIL idata_041: got %h want %h", idata, img_m[12'h041]);
    end
    for (int i = 0; i < 4; i++) begin
      iaddr = 12'($urandom_range(0, 4095));
      #1;
      vectors++;
      if (idata !== img_m[iaddr]) begin
        miscompares++;
        $display("FAIL idata_rand: addr=%h got %h want %h", iaddr, idata, img_m[iaddr]);
      end
    end
  endtask

  task automatic test_handshake();
    ld_valid = 1'b1;
    ld_data  = 13'h1fff;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (ready !== 1'b1) begin
        miscompares++;
        $display("FAIL arm_hold: cycle %0d got ready=%b want 1", i, ready);
      end
    end
    ld_valid = 1'b0;
    iaddr = 12'd0;
    #1;
    vectors++;
    if (idata !== img_m[0]) begin
      miscompares++;
      $display("FAIL ld_outside_load: got %h want %h", idata, img_m[0]);
    end
    tick();
    busy = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (ready !== 1'b0 || ld_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL arm_to_run: got ready=%b ld_ready=%b done=%b want 0/0/0", ready, ld_ready, done);
    end
    tick();
  endtask

  task automatic test_run_fill();
    for (int a = 0; a < 4096; a++) begin
      cwr = 1'b1; csel = 1'b0; caddr_wr = 12'(a); cdata_wr = 13'(a * 37 + 11);
      l0_m[a] = cdata_wr;
      tick();
    end
    for (int a = 0; a < 1024; a++) begin
      cwr = 1'b1; csel = 1'b1; caddr_wr = 12'(a); cdata_wr = 13'(a * 91 + 5) ^ 13'h1555;
      l1_m[a] = cdata_wr;
      tick();
    end
    cwr = 1'b0;
    crd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      csel = i[0];
      caddr_rd = csel ? 12'($urandom_range(0, 1023)) : 12'($urandom_range(0, 4095));
      #1;
      vectors++;
      if (cdata_rd !== (csel ? l1_m[caddr_rd[9:0]] : l0_m[caddr_rd])) begin
        miscompares++;
        $display("FAIL layer_read: sel=%b addr=%h got %h want %h", csel, caddr_rd, cdata_rd,
                 csel ? l1_m[caddr_rd[9:0]] : l0_m[caddr_rd]);
      end
    end
    crd = 1'b0;
  endtask

  task automatic test_rdw();
    cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd5; cdata_wr = 13'd3;
    tick();
    l0_m[5] = 13'd3;
    cdata_wr = 13'd9; crd = 1'b1; caddr_rd = 12'd5;
    @(negedge clk);
    vectors++;
    if (cdata_rd !== 13'd3) begin
      miscompares++;
      $display("FAIL rdw_old: got %h want 0003", cdata_rd);
    end
    tick();
    l0_m[5] = 13'd9;
    cwr = 1'b0;
    @(negedge clk);
    vectors++;
    if (cdata_rd !== 13'd9) begin
      miscompares++;
      $display("FAIL rdw_new: got %h want 0009", cdata_rd);
    end
    crd = 1'b0;
    #1;
    vectors++;
    if (cdata_rd !== 13'd0) begin
      miscompares++;
      $display("FAIL crd_low: got %h want 0000", cdata_rd);
    end
    tick();
  endtask

  task automatic test_range();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_initial: got %b want 0", err);
    end
    cwr = 1'b1; csel = 1'b1; caddr_wr = 12'd1024; cdata_wr = 13'd7;
    tick();
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd0;
    @(negedge clk);
    vectors++;
    if (err !== 1'b1 || cdata_rd !== l1_m[0]) begin
      miscompares++;
      $display("FAIL range_oob: got err=%b l1[0]=%h want 1/%h", err, cdata_rd, l1_m[0]);
    end
    tick();
    cwr = 1'b1; caddr_wr = 12'd1023; crd = 1'b0;
    tick();
    l1_m[1023] = 13'd7;
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd1023;
    @(negedge clk);
    vectors++;
    if (err !== 1'b1 || cdata_rd !== 13'd7) begin
      miscompares++;
      $display("FAIL range_1023: got err=%b l1[1023]=%h want 1/0007", err, cdata_rd);
    end
    crd = 1'b0; csel = 1'b0;
    tick();
  endtask

  // Drops busy and drains the dump until stop_at handshakes have completed.
  task automatic run_dump(input int stop_at);
    int hs = 0;
    int cyc = 0;
    bit held = 1'b0;
    dump_t hold;
    dump_t got;
    dump_t e;
    exp_q.delete();
    for (int a = 0; a < 4096; a++) exp_q.push_back('{1'b0, 12'(a), l0_m[a], 1'b0});
    for (int a = 0; a < 1024; a++) exp_q.push_back('{1'b1, 12'(a), l1_m[a], a == 1023});
    busy = 1'b0;
    dp_ready = 1'b0;
    tick();
    while (hs < stop_at && cyc < 40000) begin
      dp_ready = $urandom_range(0, 1);
      @(negedge clk);
      got = '{dp_sel, dp_addr, dp_data, dp_last};
      vectors++;
      if (dp_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL dump_valid: word %0d got dp_valid=%b want 1", hs, dp_valid);
      end
      if (held) begin
        vectors++;
        if (got !== hold) begin
          miscompares++;
          $display("FAIL dump_stable: got %h want %h", got, hold);
        end
      end
      if (dp_ready) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL dump_extra: unexpected word %h", got);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (got !== e) begin
            miscompares++;
            $display("FAIL dump_word %0d: got sel=%b addr=%h data=%h last=%b want sel=%b addr=%h data=%h last=%b",
                     hs, got.sel, got.addr, got.data, got.last, e.sel, e.addr, e.data, e.last);
          end
        end
        hs++;
        held = 1'b0;
      end else begin
        hold = got;
        held = 1'b1;
      end
      tick();
      cyc++;
    end
    dp_ready = 1'b0;
    if (hs < stop_at) begin
      miscompares++;
      $display("FAIL dump_timeout: got %0d handshakes want %0d", hs, stop_at);
    end
  endtask

  task automatic test_reset_mid_dump();
    run_dump(2000);
    reset = 1'b1;
    dp_ready = 1'b1;
    tick();
    reset = 1'b0;
    dp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dp_valid, ld_ready, done, err, dp_sel} !== 5'b01000 || dp_addr !== 12'd0 || dp_data !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid_dump: got valid/ld_ready/done/err/sel=%b addr=%h data=%h want 01000/000/0000",
               {dp_valid, ld_ready, done, err, dp_sel}, dp_addr, dp_data);
    end
    tick();
  endtask

  task automatic test_reload_rerun();
    for (int i = 0; i < 50; i++) begin
      ld_valid = 1'b1; ld_data = 13'h0f0f;
      tick();
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_image(13'h1abc);
    busy = 1'b1;
    tick();
    tick();
    crd = 1'b1; csel = 1'b0; caddr_rd = 12'd4095;
    #1;
    vectors++;
    if (cdata_rd !== l0_m[4095]) begin
      miscompares++;
      $display("FAIL l0_retained: got %h want %h", cdata_rd, l0_m[4095]);
    end
    crd = 1'b0;
    run_dump(5120);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || dp_valid !== 1'b0 || dp_last !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_done: got done=%b dp_valid=%b dp_last=%b want 1/0/0", done, dp_valid, dp_last);
    end
  endtask

  task automatic test_done_hold();
    tick();
    cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd5; cdata_wr = 13'h0aaa;
    ld_valid = 1'b1; ld_data = 13'h1111; busy = 1'b1;
    repeat (5) tick();
    cwr = 1'b0; ld_valid = 1'b0; busy = 1'b0;
    crd = 1'b1; caddr_rd = 12'd5; iaddr = 12'd0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || cdata_rd !== l0_m[5] || idata !== img_m[0]) begin
      miscompares++;
      $display("FAIL done_hold: got done=%b l0[5]=%h img[0]=%h want 1/%h/%h",
               done, cdata_rd, idata, l0_m[5], img_m[0]);
    end
    crd = 1'b0;
  endtask

  initial begin
    test_reset();
    load_image(13'h0000);
    test_handshake();
    test_run_fill();
    test_rdw();
    test_range();
    test_reset_mid_dump();
    test_reload_rerun();
    test_done_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
